// File: rtl/vga_fillarea_multi.sv
// Pipelined NRECT-rectangle compositor: shadow/active geometry banks committed at
// frame start, stage 1 per-rectangle hit test, stage 2 lowest-index priority select.
module vga_fillarea_multi #(
  parameter int NRECT = 4,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int CW    = 5,
  parameter int DW    = 16,
  parameter int AW    = $clog2(NRECT) + 3,
  localparam int RW   = (NRECT > 1) ? $clog2(NRECT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] pix_x,
  input  logic [YW-1:0] pix_y,
  input  logic          pix_valid,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          cfg_pending,
  output logic          out_valid,
  output logic          out_hit,
  output logic [CW-1:0] out_colour,
  output logic [RW-1:0] out_rect
);

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic          en;
    logic          outline;
    logic [CW-1:0] colour;
  } rect_t;

  rect_t sh_q  [NRECT];
  rect_t sh_d  [NRECT];
  rect_t act_q [NRECT];

  logic [AW-1:0] wr_idx;
  logic [2:0]    wr_field;
  logic          wr_ok;
  logic          unused_bits;

  assign wr_idx      = wr_addr >> 3;
  assign wr_field    = wr_addr[2:0];
  assign wr_ok       = wr_en && (wr_field <= 3'd4) && (wr_idx < AW'(NRECT));
  assign unused_bits = ^wr_data;

  // Next shadow contents include this cycle's write so a same-cycle commit sees it.
  always_comb begin
    for (int i = 0; i < NRECT; i++) begin
      sh_d[i] = sh_q[i];
      if (wr_ok && (wr_idx == AW'(i))) begin
        case (wr_field)
          3'd0: sh_d[i].x0 = wr_data[XW-1:0];
          3'd1: sh_d[i].y0 = wr_data[YW-1:0];
          3'd2: sh_d[i].x1 = wr_data[XW-1:0];
          3'd3: sh_d[i].y1 = wr_data[YW-1:0];
          3'd4: begin
            sh_d[i].en      = wr_data[0];
            sh_d[i].outline = wr_data[1];
            sh_d[i].colour  = wr_data[CW+1:2];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRECT; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
      cfg_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NRECT; i++) begin
        sh_q[i] <= sh_d[i];
        if (frame_start) act_q[i] <= sh_d[i];
      end
      if (frame_start)  cfg_pending <= 1'b0;
      else if (wr_ok)   cfg_pending <= 1'b1;
    end
  end

  // Stage 1: independent hit test per rectangle against the active bank.
  logic [NRECT-1:0] hit_d;
  logic [NRECT-1:0] hit_s1;
  logic [CW-1:0]    col_s1 [NRECT];
  logic             valid_s1;

  always_comb begin
    for (int i = 0; i < NRECT; i++) begin
      hit_d[i] = act_q[i].en
              && (pix_x >= act_q[i].x0) && (pix_x <= act_q[i].x1)
              && (pix_y >= act_q[i].y0) && (pix_y <= act_q[i].y1)
              && (!act_q[i].outline
                  || (pix_x == act_q[i].x0) || (pix_x == act_q[i].x1)
                  || (pix_y == act_q[i].y0) || (pix_y == act_q[i].y1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_s1   <= '0;
      valid_s1 <= 1'b0;
      for (int i = 0; i < NRECT; i++) col_s1[i] <= '0;
    end else begin
      hit_s1   <= hit_d;
      valid_s1 <= pix_valid;
      for (int i = 0; i < NRECT; i++) col_s1[i] <= act_q[i].colour;
    end
  end

  // Stage 2: scan from the top index down so the lowest hitting index wins.
  logic          win_hit;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_idx;

  always_comb begin
    win_hit = 1'b0;
    win_col = '0;
    win_idx = '0;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        win_hit = 1'b1;
        win_col = col_s1[i];
        win_idx = RW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_hit    <= 1'b0;
      out_colour <= '0;
      out_rect   <= '0;
    end else begin
      out_valid  <= valid_s1;
      out_hit    <= win_hit && valid_s1;
      out_colour <= (win_hit && valid_s1) ? win_col : '0;
      out_rect   <= (win_hit && valid_s1) ? win_idx : '0;
    end
  end

endmodule
